// File: rtl/prog_loader_if.sv
// Byte stream from the serial receiver into the program loader.
// The receiver is the master and the loader is the slave; a byte moves when valid && ready.
interface prog_loader_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/prog_loader.sv
// Boot loader: parses a counted, XOR-checked byte frame into 16-bit words for instruction
// memory and keeps the CPU in reset until the whole frame has been written and verified.
module prog_loader #(
    parameter int ADDR_W         = 9,
    parameter int DEPTH          = 512,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic              clk,
    input  logic              reset,
    prog_loader_if.slave      rx,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [15:0]       imem_wdata,
    output logic              cpu_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_RUN, S_ERROR
    } state_t;

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [15:0]     DEPTH_N = 16'(DEPTH);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            state;
    logic [7:0]        cnt_hi;
    logic [7:0]        data_hi;
    logic [7:0]        chk;
    logic [15:0]       n_words;
    logic [ADDR_W-1:0] word_cnt;
    logic [TO_W-1:0]   to_cnt;

    logic        xfer;
    logic        timing;
    logic        last_word;
    logic [15:0] n_rx;

    assign rx.ready  = state inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
    assign xfer      = rx.valid && rx.ready;
    assign timing    = state inside {S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK};
    assign n_rx      = {cnt_hi, rx.data};
    // n_words >= 1 whenever DATA_LO is reachable, so the subtraction never wraps here.
    assign last_word = (16'(word_cnt) == n_words - 16'd1);

    // NOTE: all state lives in this one clocked block and uses <= so every branch sees
    // the values from before the edge, regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_CNT_HI;
            cnt_hi     <= '0;
            data_hi    <= '0;
            chk        <= '0;
            n_words    <= '0;
            word_cnt   <= '0;
            to_cnt     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            if (reload) begin
                // A byte offered alongside reload is deliberately dropped.
                state     <= S_CNT_HI;
                chk       <= '0;
                word_cnt  <= '0;
                to_cnt    <= '0;
                cpu_reset <= 1'b1;
                done      <= 1'b0;
                error     <= 1'b0;
            end else begin
                // Every state change inside a frame is caused by a transfer, so clearing on
                // transfer also clears on state entry.
                if (xfer || !timing) to_cnt <= '0;
                else                 to_cnt <= to_cnt + TO_W'(1);

                if (xfer && state != S_CHECK) chk <= chk ^ rx.data;

                case (state)
                    S_CNT_HI: if (xfer) begin
                        cnt_hi <= rx.data;
                        state  <= S_CNT_LO;
                    end
                    S_CNT_LO: if (xfer) begin
                        n_words <= n_rx;
                        if (n_rx > DEPTH_N) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end else if (n_rx == 16'd0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                    S_DATA_HI: if (xfer) begin
                        data_hi <= rx.data;
                        state   <= S_DATA_LO;
                    end
                    S_DATA_LO: if (xfer) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_cnt;
                        imem_wdata <= {data_hi, rx.data};
                        word_cnt   <= word_cnt + ADDR_W'(1);
                        state      <= last_word ? S_CHECK : S_DATA_HI;
                    end
                    S_CHECK: if (xfer) begin
                        if (rx.data == chk) begin
                            state     <= S_RUN;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state <= S_ERROR;
                            error <= 1'b1;
                        end
                    end
                    S_RUN, S_ERROR: ;
                    default: begin
                        state <= S_ERROR;
                        error <= 1'b1;
                    end
                endcase

                if (timing && !xfer && to_cnt == TO_LAST) begin
                    state <= S_ERROR;
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame parsing, checksum, length limits, timeout,
// reload priority, asynchronous reset and a full-depth back-to-back frame.
module tb_prog_loader;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;
    localparam int TO     = 16;
    localparam int LOG_SZ = 600;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              reload = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    prog_loader_if rx_if ();

    prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx_if.slave),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Write log, sampled on the falling edge, half a cycle after the registered strobe.
    int                wr_n = 0;
    logic [ADDR_W-1:0] wr_addr [LOG_SZ];
    logic [15:0]       wr_data [LOG_SZ];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (wr_n < LOG_SZ) begin
                wr_addr[wr_n] = imem_addr;
                wr_data[wr_n] = imem_wdata;
            end
            wr_n++;
        end
    end

    // Stimulus tasks are entered on a falling edge and return on a falling edge.
    task automatic send_byte(input logic [7:0] b);
        rx_if.valid = 1'b1;
        rx_if.data  = b;
        @(negedge clk);
        rx_if.valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (rx_if.ready !== 1'b1) begin errors++; $display("FAIL reset_rx_ready: got %b want 1", rx_if.ready); end
        checks++; if (cpu_reset !== 1'b1) begin errors++; $display("FAIL reset_cpu_reset: got %b want 1", cpu_reset); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
        checks++; if (imem_addr !== 9'd0) begin errors++; $display("FAIL reset_imem_addr: got %h want 000", imem_addr); end
        checks++; if (imem_wdata !== 16'h0000) begin errors++; $display("FAIL reset_imem_wdata: got %h want 0000", imem_wdata); end
        @(negedge clk);
        reset = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        wr_n = 0;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h42);
        idle(3);
        checks++; if (wr_n !== 2) begin errors++; $display("FAIL basic_writes: got %0d want 2", wr_n); end
        checks++; if (wr_addr[0] !== 9'd0 || wr_data[0] !== 16'h1234) begin errors++; $display("FAIL basic_word0: got %h@%h want 1234@000", wr_data[0], wr_addr[0]); end
        checks++; if (wr_addr[1] !== 9'd1 || wr_data[1] !== 16'hABCD) begin errors++; $display("FAIL basic_word1: got %h@%h want abcd@001", wr_data[1], wr_addr[1]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
        checks++; if (cpu_reset !== 1'b0) begin errors++; $display("FAIL basic_cpu_reset: got %b want 0", cpu_reset); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", error); end
        checks++; if (rx_if.ready !== 1'b0) begin errors++; $display("FAIL basic_rx_ready: got %b want 0", rx_if.ready); end
    endtask

    task automatic test_bad_checksum();
        pulse_reload();
        checks++; if (done !== 1'b0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL reload_clears: done=%b cpu_reset=%b want 0/1", done, cpu_reset); end
        wr_n = 0;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h43);
        idle(3);
        checks++; if (wr_n !== 2) begin errors++; $display("FAIL badchk_writes: got %0d want 2", wr_n); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL badchk_error: got %b want 1", error); end
        checks++; if (cpu_reset !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL badchk_cpu: cpu_reset=%b done=%b want 1/0", cpu_reset, done); end
        checks++; if (rx_if.ready !== 1'b0) begin errors++; $display("FAIL badchk_rx_ready: got %b want 0", rx_if.ready); end
        pulse_reload();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reload_error_clear: got %b want 0", error); end
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h42);
        idle(2);
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL reload_retry: done=%b error=%b want 1/0", done, error); end
    endtask

    task automatic test_lengths();
        pulse_reload();
        // Byte offered in the same cycle as reload must be dropped.
        reload      = 1'b1;
        rx_if.valid = 1'b1;
        rx_if.data  = 8'h05;
        @(negedge clk);
        reload      = 1'b0;
        rx_if.valid = 1'b0;
        wr_n = 0;
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        idle(3);
        checks++; if (wr_n !== 0) begin errors++; $display("FAIL empty_writes: got %0d want 0", wr_n); end
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL empty_done: done=%b error=%b want 1/0", done, error); end
        pulse_reload();
        wr_n = 0;
        send_byte(8'h02); send_byte(8'h01);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL oversize_error: got %b want 1", error); end
        idle(3);
        checks++; if (wr_n !== 0 || rx_if.ready !== 1'b0) begin errors++; $display("FAIL oversize_quiet: writes=%0d rx_ready=%b want 0/0", wr_n, rx_if.ready); end
    endtask

    task automatic test_timeout();
        pulse_reload();
        wr_n = 0;
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
        idle(10);
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", error); end
        idle(10);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL timeout_error: got %b want 1", error); end
        checks++; if (wr_n !== 0 || cpu_reset !== 1'b1) begin errors++; $display("FAIL timeout_quiet: writes=%0d cpu_reset=%b want 0/1", wr_n, cpu_reset); end
        pulse_reload();
        idle(1000);
        checks++; if (error !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL cnt_hi_wait: error=%b done=%b want 0/0", error, done); end
        checks++; if (rx_if.ready !== 1'b1) begin errors++; $display("FAIL cnt_hi_ready: got %b want 1", rx_if.ready); end
    endtask

    task automatic test_async_reset();
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        send_byte(8'h33);
        checks++; if (imem_addr !== 9'd1 || imem_wdata !== 16'h2222) begin errors++; $display("FAIL pre_reset_word: got %h@%h want 2222@001", imem_wdata, imem_addr); end
        #2 reset = 1'b0;
        #1;
        checks++; if (imem_addr !== 9'd0 || imem_wdata !== 16'h0000 || imem_we !== 1'b0) begin errors++; $display("FAIL async_imem: we=%b addr=%h data=%h want 0/000/0000", imem_we, imem_addr, imem_wdata); end
        checks++; if (cpu_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0 || rx_if.ready !== 1'b1) begin errors++; $display("FAIL async_ctrl: cpu_reset=%b done=%b error=%b rx_ready=%b want 1/0/0/1", cpu_reset, done, error, rx_if.ready); end
        @(negedge clk);
        reset = 1'b1;
        wr_n = 0;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF);
        send_byte(8'h50);
        idle(3);
        checks++; if (wr_n !== 1 || wr_addr[0] !== 9'd0 || wr_data[0] !== 16'hBEEF) begin errors++; $display("FAIL post_reset_load: writes=%0d got %h@%h want 1 beef@000", wr_n, wr_data[0], wr_addr[0]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL post_reset_done: got %b want 1", done); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  c;
        logic [15:0] w;
        int          bad;
        pulse_reload();
        wr_n = 0;
        c = 8'h02;
        send_byte(8'h02); send_byte(8'h00);
        for (int i = 0; i < DEPTH; i++) begin
            w = {8'(i), 8'(i * 7 + 3)};
            c = c ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_byte(c);
        idle(3);
        checks++; if (wr_n !== DEPTH) begin errors++; $display("FAIL b2b_writes: got %0d want %0d", wr_n, DEPTH); end
        bad = 0;
        for (int i = 0; i < DEPTH && i < LOG_SZ; i++) begin
            w = {8'(i), 8'(i * 7 + 3)};
            if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== w) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_words: %0d of %0d words wrong addr/data, want 0", bad, DEPTH); end
        checks++; if (done !== 1'b1 || error !== 1'b0) begin errors++; $display("FAIL b2b_done: done=%b error=%b want 1/0", done, error); end
        checks++; if (imem_addr !== 9'd511) begin errors++; $display("FAIL b2b_last_addr: got %0d want 511", imem_addr); end
    endtask

    initial begin
        rx_if.valid = 1'b0;
        rx_if.data  = 8'h00;
        test_reset();
        test_basic();
        test_bad_checksum();
        test_lengths();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
